// File: rtl/alu_sequencer.sv
// ALU datapath sequencer: pops commands from FIFO_IN, runs add or
// shift-add multiply, pushes tagged results to FIFO_OUT.
module alu_sequencer #(
  parameter int OPERATION_SIZE = 2,
  parameter int DATA_WIDTH     = 12,
  parameter int FIFO_IN_WIDTH  = OPERATION_SIZE + 2 * DATA_WIDTH,
  parameter int FIFO_OUT_WIDTH = 2 * DATA_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FIFO_IN_WIDTH-1:0]  in_rdata,
  input  logic                      in_empty,
  output logic                      r_en_in,
  input  logic                      out_full,
  output logic                      w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0] out_wdata,
  output logic                      busy,
  output logic                      op_err
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] POP      = 3'd1;
  localparam logic [2:0] LOAD     = 3'd2;
  localparam logic [2:0] EXEC_ADD = 3'd3;
  localparam logic [2:0] EXEC_MUL = 3'd4;
  localparam logic [2:0] PUSH     = 3'd5;

  localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(2);

  logic [2:0]                state;
  logic [2:0]                state_nx;
  logic [PW-1:0]             a_q;
  logic [DATA_WIDTH-1:0]     b_q;
  logic [PW-1:0]             acc_q;
  logic [CW-1:0]             cnt_q;

  logic [OPERATION_SIZE-1:0] cmd_op;
  logic [DATA_WIDTH-1:0]     cmd_d1;
  logic [DATA_WIDTH-1:0]     cmd_d0;
  logic                      is_add;
  logic                      is_mul;
  logic [DATA_WIDTH:0]       sum;
  logic [PW-1:0]             acc_nx;
  logic                      mul_last;

  assign cmd_op = in_rdata[FIFO_IN_WIDTH-1 -: OPERATION_SIZE];
  assign cmd_d1 = in_rdata[PW-1:DATA_WIDTH];
  assign cmd_d0 = in_rdata[DATA_WIDTH-1:0];
  assign is_add = (cmd_op == OP_ADD);
  assign is_mul = (cmd_op == OP_MUL);

  assign sum      = {1'b0, a_q[DATA_WIDTH-1:0]} + {1'b0, b_q};
  // a_q is pre-shifted each step, so it always holds a << step index
  assign acc_nx   = acc_q + (b_q[0] ? a_q : '0);
  assign mul_last = (cnt_q == CW'(1));

  assign r_en_in  = (state == POP);
  assign w_en_out = (state == PUSH) && !out_full;
  assign busy     = (state != IDLE);
  assign op_err   = (state == LOAD) && !is_add && !is_mul;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (!in_empty) state_nx = POP;
      POP:      state_nx = LOAD;
      LOAD: begin
        unique case (1'b1)
          is_add:  state_nx = EXEC_ADD;
          is_mul:  state_nx = EXEC_MUL;
          default: state_nx = IDLE;
        endcase
      end
      EXEC_ADD: state_nx = PUSH;
      EXEC_MUL: if (mul_last) state_nx = PUSH;
      PUSH:     if (!out_full) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          a_q <= PW'(cmd_d0);
          b_q <= cmd_d1;
          if (is_mul) begin
            acc_q <= '0;
            cnt_q <= CW'(DATA_WIDTH);
          end
        end
        EXEC_MUL: begin
          acc_q <= acc_nx;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result is latched on PUSH entry and held until the next PUSH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wdata <= '0;
    end else begin
      unique case (1'b1)
        (state == EXEC_ADD):
          out_wdata <= FIFO_OUT_WIDTH'(sum);
        (state == EXEC_MUL) && mul_last:
          out_wdata <= {1'b1, acc_nx};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a queue-backed FIFO_IN model
// and a posedge monitor that logs strobes and pushed results.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] in_rdata = '0;
  logic        in_empty = 1'b1;
  logic        r_en_in;
  logic        out_full;
  logic        w_en_out;
  logic [24:0] out_wdata;
  logic        busy;
  logic        op_err;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_rdata  (in_rdata),
    .in_empty  (in_empty),
    .r_en_in   (r_en_in),
    .out_full  (out_full),
    .w_en_out  (w_en_out),
    .out_wdata (out_wdata),
    .busy      (busy),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  logic [25:0] cmd_q[$];
  logic [24:0] res_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rcnt = 0;
  int          wcnt = 0;
  int          errcnt = 0;
  int          overlap = 0;
  int          gap = 0;
  int          popcyc = 0;
  int          wcyc = 0;
  logic        inflight = 1'b0;
  logic        fifo_re;

  function automatic logic [25:0] mk(input logic [1:0] op,
                                     input logic [11:0] d1,
                                     input logic [11:0] d0);
    return {op, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take_res(input string tag, input logic [24:0] exp);
    if (res_q.size() > 0) check(tag, 64'(res_q.pop_front()), 64'(exp));
    else check({tag, "_missing"}, 64'hDEAD, 64'(exp));
  endtask

  task automatic wait_w(input int target, input int limit);
    int k;
    k = 0;
    while (wcnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (wcnt < target) check("wait_timeout", 64'(wcnt), 64'(target));
  endtask

  // FIFO_IN model: data appears the cycle after a pop
  always @(posedge clk) begin
    fifo_re = r_en_in;
    #1;
    if (fifo_re && cmd_q.size() > 0) in_rdata = cmd_q.pop_front();
    in_empty = (cmd_q.size() == 0);
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) inflight = 1'b0;
    if (inflight && !busy) gap++;
    if (r_en_in && w_en_out) overlap++;
    if (r_en_in) begin
      rcnt++;
      popcyc = cyc;
      inflight = 1'b1;
    end
    if (w_en_out) begin
      wcnt++;
      wcyc = cyc;
      res_q.push_back(out_wdata);
      inflight = 1'b0;
    end
    if (op_err) begin
      errcnt++;
      inflight = 1'b0;
    end
  end

  initial begin
    int r0;
    int w0;
    int e0;
    int k;
    rst_n = 1'b0;
    out_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_r_en", 64'(r_en_in), 0);
    check("rst_w_en", 64'(w_en_out), 0);
    check("rst_op_err", 64'(op_err), 0);
    check("rst_wdata", 64'(out_wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single ADD
    r0 = rcnt;
    cmd_q.push_back(mk(2'b01, 12'd100, 12'd23));
    wait_w(wcnt + 1, 60);
    take_res("add_res", 25'h000007B);
    check("add_lat", 64'(wcyc - popcyc + 1), 4);
    check("add_pops", 64'(rcnt - r0), 1);
    repeat (3) @(negedge clk);

    // MUL max operands
    gap = 0;
    cmd_q.push_back(mk(2'b10, 12'hFFF, 12'hFFF));
    wait_w(wcnt + 1, 60);
    take_res("mul_max", {1'b1, 24'hFFE001});
    check("mul_lat", 64'(wcyc - popcyc + 1), 15);
    check("mul_busy_gap", 64'(gap), 0);
    repeat (3) @(negedge clk);

    // backpressure with a second command queued behind
    out_full = 1'b1;
    r0 = rcnt;
    w0 = wcnt;
    cmd_q.push_back(mk(2'b10, 12'd5, 12'd3));
    cmd_q.push_back(mk(2'b01, 12'd7, 12'd8));
    repeat (25) @(negedge clk);
    check("bp_no_push", 64'(wcnt), 64'(w0));
    check("bp_one_pop", 64'(rcnt - r0), 1);
    check("bp_busy", 64'(busy), 1);
    check("bp_wdata", 64'(out_wdata), 64'h100000F);
    repeat (7) @(negedge clk);
    check("bp_hold_wdata", 64'(out_wdata), 64'h100000F);
    check("bp_hold_pop", 64'(rcnt - r0), 1);
    out_full = 1'b0;
    @(negedge clk);
    check("bp_push", 64'(wcnt - w0), 1);
    take_res("bp_res", 25'h100000F);
    wait_w(w0 + 2, 60);
    take_res("bp_next_add", 25'h000000F);
    repeat (3) @(negedge clk);

    // illegal ops
    e0 = errcnt;
    w0 = wcnt;
    cmd_q.push_back(mk(2'b11, 12'd1, 12'd2));
    cmd_q.push_back(mk(2'b00, 12'd3, 12'd4));
    repeat (20) @(negedge clk);
    check("ill_errs", 64'(errcnt - e0), 2);
    check("ill_no_push", 64'(wcnt), 64'(w0));
    check("ill_idle", 64'(busy), 0);

    // back-to-back ADD stream
    overlap = 0;
    r0 = rcnt;
    w0 = wcnt;
    cmd_q.push_back(mk(2'b01, 12'd2, 12'd1));
    cmd_q.push_back(mk(2'b01, 12'hFFF, 12'hFFF));
    cmd_q.push_back(mk(2'b01, 12'd20, 12'd10));
    cmd_q.push_back(mk(2'b01, 12'h800, 12'h800));
    wait_w(w0 + 4, 100);
    take_res("str0", 25'h0000003);
    take_res("str1", 25'h0001FFE);
    take_res("str2", 25'h000001E);
    take_res("str3", 25'h0001000);
    check("str_pops", 64'(rcnt - r0), 4);
    check("str_overlap", 64'(overlap), 0);
    repeat (3) @(negedge clk);

    // reset during 6th multiply step
    r0 = rcnt;
    w0 = wcnt;
    cmd_q.push_back(mk(2'b10, 12'd9, 12'd9));
    k = 0;
    while (rcnt == r0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_pop", 64'(rcnt - r0), 1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 0);
    check("mid_r_en", 64'(r_en_in), 0);
    check("mid_w_en", 64'(w_en_out), 0);
    check("mid_op_err", 64'(op_err), 0);
    check("mid_wdata", 64'(out_wdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_no_push", 64'(wcnt), 64'(w0));
    check("mid_idle", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
